// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Shift-add multiply or restoring divide, 32 iterations plus a sign-fix cycle.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [1:0]  opReg;
  logic        signA, signB;
  logic [31:0] magA, magB;
  logic [31:0] upper, lower;   // {P,Q} for multiply, {R,Q} for divide
  logic [5:0]  cnt;

  logic        isDiv, isSigned, negProd, negRem;
  logic [31:0] absA, absB;
  logic [32:0] mulSum, divShift;
  logic        divGe;
  logic [31:0] divDiff, quot, remd, rawA;
  logic [63:0] prod, prodFix;

  always_comb begin
    isDiv    = opReg[1];
    isSigned = opReg[0];
    absA     = (op[0] && a[31]) ? -a : a;
    absB     = (op[0] && b[31]) ? -b : b;
    mulSum   = {1'b0, upper} + (lower[0] ? {1'b0, magA} : 33'd0);
    divShift = {upper, lower[31]};
    divGe    = divShift >= {1'b0, magB};
    // Remainder after a successful subtract is below magB, so 32 bits suffice.
    divDiff  = divShift[31:0] - magB;
    negProd  = isSigned && (signA ^ signB);
    negRem   = isSigned && signA;
    prod     = {upper, lower};
    prodFix  = negProd ? -prod : prod;
    quot     = negProd ? -lower : lower;
    remd     = negRem ? -upper : upper;
    rawA     = negRem ? -magA : magA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      opReg       <= 2'd0;
      signA       <= 1'b0;
      signB       <= 1'b0;
      magA        <= 32'd0;
      magB        <= 32'd0;
      upper       <= 32'd0;
      lower       <= 32'd0;
      cnt         <= 6'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opReg       <= op;
            signA       <= a[31];
            signB       <= b[31];
            magA        <= absA;
            magB        <= absB;
            upper       <= 32'd0;
            lower       <= op[1] ? absA : absB;
            cnt         <= 6'd0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            state       <= CALC;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          if (isDiv) begin
            upper <= divGe ? divDiff : divShift[31:0];
            lower <= {lower[30:0], divGe};
          end else begin
            upper <= mulSum[32:1];
            lower <= {mulSum[0], lower[31:1]};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          if (isDiv && magB == 32'd0) begin
            hi          <= rawA;
            lo          <= 32'hFFFF_FFFF;
            div_by_zero <= 1'b1;
          end else if (isDiv) begin
            hi <= remd;
            lo <= quot;
          end else begin
            hi <= prodFix[63:32];
            lo <= prodFix[31:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_mult_div_unit;
  logic        clk = 1'b0, rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, busyCnt = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          t0;
  } exp_t;
  exp_t sb[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {dbz, hi, lo}
  function automatic logic [64:0] model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    longint          sx = $signed(x);
    longint          sy = $signed(y);
    longint unsigned ux = x;
    longint unsigned uy = y;
    logic [63:0]     p;
    logic [31:0]     qv, rv;
    if (o == 2'd0) begin
      p = ux * uy;
      return {1'b0, p};
    end
    if (o == 2'd1) begin
      p = sx * sy;
      return {1'b0, p};
    end
    if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
    if (o == 2'd2) begin
      qv = 32'(ux / uy);
      rv = 32'(ux % uy);
    end else begin
      qv = 32'(sx / sy);
      rv = 32'(sx % sy);
    end
    return {1'b0, rv, qv};
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (busy) busyCnt++;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        chk("latency", 64'(cyc - e.t0), 64'd33);
        chk("busy_cycles", 64'(busyCnt), 64'd33);
      end
    end
    if (!busy) busyCnt = 0;
  end

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic issue(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    exp_t        e;
    logic [64:0] m;
    waitIdle();
    m     = model(o, x, y);
    e.dbz = m[64];
    e.hi  = m[63:32];
    e.lo  = m[31:0];
    e.t0  = cyc + 1;
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  initial begin
    int n;
    logic [31:0] specials[6];
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_FFFF};
    rst = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);

    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'd1, 32'hFFFF_FFFD, 32'd5);
    issue(2'd1, 32'h8000_0000, 32'h8000_0000);
    issue(2'd3, 32'hFFFF_FFF9, 32'd2);
    issue(2'd2, 32'd100, 32'd7);
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'd2, 32'h1234, 32'd0);
    issue(2'd0, 32'd2, 32'd3);

    // Start and mthi while busy must both be ignored.
    issue(2'd2, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd55; b = 32'd66;
    hi_we = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    hi_we = 1'b0;
    waitIdle();
    hi_we = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_idle", 64'(hi), 64'hAAAA_5555);
    lo_we = 1'b1; wdata = 32'h0F0F_0F0F;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_idle", 64'(lo), 64'h0F0F_0F0F);

    // Reset mid-divide aborts with no done.
    issue(2'd3, 32'hFFFF_FF00, 32'd7);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    issue(2'd0, 32'd3, 32'd4);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      x = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) y = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom_range(1, 15);
      issue(2'($urandom_range(0, 3)), x, y);
    end

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    repeat (40) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
